// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARB        = 3'd1,
    S_LAUNCH     = 3'd2,
    S_WAIT_START = 3'd3,
    S_BUSY       = 3'd4,
    S_GAP        = 3'd5
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bundle: one byte lane per requester plus its valid/ready pair.
//
// Handshake: requester i raises req_valid[i] with its byte on
// req_data[8*i+7:8*i] and holds both until it sees req_ready[i] high on a
// clock edge; req_ready is a one-hot, single-cycle acceptance pulse. A byte
// is transferred on the edge where req_valid[i] and req_ready[i] are both 1.
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // Scan from the pointer upward; the first hit wins and later hits are ignored.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = IDX_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one tx_uart between NUM_REQ byte requesters: round-robin grant,
// launch pulse, end-of-frame tracking and an idle guard gap between frames.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CLKS      = 217,
  parameter int START_TIMEOUT = 16,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_scheduler_if.slave req,
  output logic               tx_dv,
  output logic [BYTE_W-1:0]  tx_byte,
  input  logic               tx_active,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               err_timeout,
  output sched_state_e       dbg_state
);

  // A zero gap never enters GAP, but the counter still needs one bit to exist.
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  sched_state_e      state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [BYTE_W-1:0]  sel_byte;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req.req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign sel_byte  = req.req_data[BYTE_W*int'(gnt_idx) +: BYTE_W];
  assign next_ptr  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign dbg_state = state;

  // Acceptance is visible only during ARB, so a requester that drops valid
  // there simply falls out of the arbiter and is not acknowledged.
  always_comb begin
    req.req_ready = '0;
    if (state == S_ARB) req.req_ready = gnt_onehot;
  end

  // Scheduler FSM with registered launch, byte, owner, busy and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_dv       <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          // A frame still on the line (e.g. reset mid-frame) blocks any grant.
          if ((|req.req_valid) && !tx_active) begin
            state <= S_ARB;
            busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (gnt_any) begin
            tx_byte  <= sel_byte;
            grant_id <= gnt_idx;
            rr_ptr   <= next_ptr;
            tx_dv    <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (tx_active) begin
            state <= S_BUSY;
          end else if (tmo_cnt == TMO_LAST) begin
            // Serializer never started: drop the byte and report it.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (!tx_active) begin
            if (GAP_CLKS == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with a behavioural tx_uart stand-in.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int GAP_CLKS  = 8;
  localparam int START_TMO = 16;
  localparam int START_DLY = 2;
  localparam int FRAME     = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle index, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         tx_active;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err_timeout;
  sched_state_e dbg_state;

  uart_tx_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .GAP_CLKS      (GAP_CLKS),
    .START_TIMEOUT (START_TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (bus),
    .tx_dv       (tx_dv),
    .tx_byte     (tx_byte),
    .tx_active   (tx_active),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];
  int gaps[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] b);
    logic [1:0] id2;
    id2 = 2'(id);
    exp_q.push_back({id2, b});
  endtask

  task automatic set_data(input int i, input logic [7:0] b);
    bus.req_data[8*i +: 8] = b;
  endtask

  // ---------------- tx_uart stand-in ----------------
  logic stub_en = 1'b1;
  logic hold_active = 1'b0;

  initial begin
    tx_active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_dv && stub_en) begin
        repeat (START_DLY) begin @(posedge clk); #1; end
        tx_active = 1'b1;
        repeat (FRAME) begin @(posedge clk); #1; end
        while (hold_active) begin @(posedge clk); #1; end
        tx_active = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_active = 1'b0;
  logic has_fall = 1'b0;
  int   fall_cyc = 0;

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_dv) begin
          check("launch_while_active", 32'(tx_active), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_launch: got id %0d byte 0x%0h expected none at cycle %0d",
                     grant_id, tx_byte, cyc);
          end else begin
            e = exp_q.pop_front();
            check("launch_id_byte", 32'({grant_id, tx_byte}), 32'(e));
          end
          gaps.push_back(has_fall ? cyc - fall_cyc : -1);
          has_fall = 1'b0;
        end
        if (bus.req_ready != '0) begin
          check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
          check("ready_has_valid", 32'((bus.req_ready & bus.req_valid) == bus.req_ready), 32'd1);
        end
        if (prev_active && !tx_active) begin
          fall_cyc = cyc;
          has_fall = 1'b1;
        end
      end
      prev_active = tx_active;
    end
  end

  // ---------------- driver tasks ----------------
  int ready_cnt, dv_cnt, err_cnt, last_dv, last_err;
  sched_state_e err_state;
  logic err_busy;

  // One cycle: sample at the falling edge, retire accepted requests after the next rising edge.
  task automatic step();
    logic [NUM_REQ-1:0] rdy;
    @(negedge clk);
    rdy = bus.req_ready;
    if (bus.req_ready != '0) ready_cnt++;
    if (tx_dv) begin dv_cnt++; last_dv = cyc; end
    if (err_timeout) begin
      err_cnt++;
      last_err  = cyc;
      err_state = dbg_state;
      err_busy  = busy;
    end
    @(posedge clk); #1;
    bus.req_valid = bus.req_valid & ~rdy;
  endtask

  task automatic serve(input string name, input int budget);
    int n;
    n = 0;
    while (bus.req_valid != '0 && n < budget) begin step(); n++; end
    check({name, "_served"}, 32'(bus.req_valid), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin step(); n++; end
    while (!(dbg_state == S_IDLE && !tx_active) && n < budget);
    check({name, "_idle"}, 32'(dbg_state == S_IDLE && !tx_active), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, n;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 2: all four valid from pointer 0 -> 0,1,2,3 with a fixed guard gap
    set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
    push_exp(0, 8'h10); push_exp(1, 8'h21); push_exp(2, 8'h32); push_exp(3, 8'h43);
    n0 = gaps.size();
    bus.req_valid = 4'b1111;
    serve("t2", 600);
    wait_idle("t2", 200);
    check("t2_launches", 32'(gaps.size() - n0), 32'd4);
    if (gaps.size() - n0 == 4) begin
      for (int i = 1; i < 4; i++)
        check("t2_gap", 32'(gaps[n0+i]), 32'(GAP_CLKS + 3));
    end

    // Test 1: single request latency (ready at t+1, launch at t+2)
    set_data(0, 8'hA5);
    push_exp(0, 8'hA5);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready_early", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready), 32'b0001);
    check("t1_no_dv_yet", 32'(tx_dv), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_tx_dv", 32'(tx_dv), 32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", 200);

    // Test 3: move pointer to 2 via requester 1, then 1+3 -> 3 then 1 (wrap)
    set_data(1, 8'h11); push_exp(1, 8'h11);
    bus.req_valid = 4'b0010;
    serve("t3a", 100); wait_idle("t3a", 200);
    set_data(1, 8'h81); set_data(3, 8'h83);
    push_exp(3, 8'h83); push_exp(1, 8'h81);
    bus.req_valid = 4'b1010;
    serve("t3b", 300); wait_idle("t3b", 200);
    // pointer is back at 2: requesters 0 and 2 -> 2 first, then 0
    set_data(0, 8'h90); set_data(2, 8'h92);
    push_exp(2, 8'h92); push_exp(0, 8'h90);
    bus.req_valid = 4'b0101;
    serve("t3c", 300); wait_idle("t3c", 200);

    // Test 4: serializer never starts -> timeout START_TMO+1 clks after launch
    stub_en = 1'b0;
    set_data(0, 8'h5A); push_exp(0, 8'h5A);
    err_cnt = 0; dv_cnt = 0;
    bus.req_valid = 4'b0001;
    repeat (40) step();
    check("t4_err_count", 32'(err_cnt), 32'd1);
    check("t4_dv_count", 32'(dv_cnt), 32'd1);
    check("t4_err_delay", 32'(last_err - last_dv), 32'(START_TMO + 1));
    check("t4_err_state", 32'(err_state), 32'(S_IDLE));
    check("t4_err_busy", 32'(err_busy), 32'd0);
    stub_en = 1'b1;
    // pointer now 1: a lone request from 3 is granted normally
    set_data(3, 8'hC3); push_exp(3, 8'hC3);
    bus.req_valid = 4'b1000;
    serve("t4b", 100); wait_idle("t4b", 200);

    // Test 6: one-clock pulse on req_valid[2] in IDLE -> ARB with nothing to grant
    set_data(2, 8'hEE);
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("t6_in_arb", 32'(dbg_state), 32'(S_ARB));
    check("t6_no_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    ready_cnt = 0; dv_cnt = 0;
    repeat (6) step();
    check("t6_ready_cnt", 32'(ready_cnt), 32'd0);
    check("t6_dv_cnt", 32'(dv_cnt), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));

    // Test 5: reset while BUSY, then hold off until tx_active falls
    hold_active = 1'b1;
    set_data(2, 8'h77); push_exp(2, 8'h77);
    bus.req_valid = 4'b0100;
    n = 0;
    while (dbg_state != S_BUSY && n < 60) begin step(); n++; end
    check("t5_reached_busy", 32'(dbg_state), 32'(S_BUSY));
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx_dv", 32'(tx_dv), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_grant", 32'(grant_id), 32'd0);
    check("t5_rst_byte", 32'(tx_byte), 32'd0);
    check("t5_rst_err", 32'(err_timeout), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'(S_IDLE));
    set_data(1, 8'h3C);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ready_cnt = 0; dv_cnt = 0;
    repeat (12) step();
    check("t5_hold_ready", 32'(ready_cnt), 32'd0);
    check("t5_hold_dv", 32'(dv_cnt), 32'd0);
    check("t5_hold_state", 32'(dbg_state), 32'(S_IDLE));
    push_exp(1, 8'h3C);
    hold_active = 1'b0;
    serve("t5b", 200); wait_idle("t5b", 200);

    // Final report
    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
